// File: rtl/serial_sub_seq_pkg.sv
// serial_sub_pkg: shared state encoding for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_sub_seq_if.sv
// serial_sub_seq_if: operand/result handshake bundle for the serial subtractor
interface serial_sub_seq_if #(parameter int WIDTH = 8) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf, busy);
  modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf, busy);
endinterface

// File: rtl/serial_sub_seq_fs_bit.sv
// fs_bit: combinational one-bit full subtractor cell
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

// File: rtl/serial_sub_seq.sv
// serial_sub_seq: bit-serial a - b - bin using one full-subtractor cell over WIDTH cycles
module serial_sub_seq
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_sub_seq_if.slave  io
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t st, st_n;
  logic [WIDTH-1:0] sa, sb, diff_r;
  logic [CW-1:0] cnt;
  logic br, bout_r, ovf_r, d, bo, last;
  fs_bit u_cell (.a(sa[0]), .b(sb[0]), .bi(br), .d(d), .bo(bo));
  assign last = cnt == CW'(WIDTH - 1);
  // state register
  always_ff @(posedge clk) st <= rst ? IDLE : st_n;
  // next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    st_n = st == IDLE ? (io.in_valid ? RUN : IDLE) :
           st == RUN  ? (last ? DONE : RUN) :
           st == DONE ? (io.out_ready ? IDLE : DONE) : IDLE;
  end
  // handshake and result outputs
  always_comb begin
    io.in_ready  = st == IDLE;
    io.out_valid = st == DONE;
    io.busy      = st == RUN || st == DONE;
    io.diff      = diff_r;
    io.bout      = bout_r;
    io.ovf       = ovf_r;
  end
  // operand shift registers, borrow chain, counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (st == IDLE && io.in_valid) begin
      sa     <= io.a;
      sb     <= io.b;
      br     <= io.bin;
      cnt    <= '0;
      diff_r <= '0;
    end else if (st == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      br     <= bo;
      diff_r <= WIDTH'({d, diff_r} >> 1);
      cnt    <= last ? cnt : cnt + CW'(1);
      if (last) begin
        bout_r <= bo;
        ovf_r  <= (sa[0] != sb[0]) && (d != sa[0]);
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_seq.sv
// tb_serial_sub_seq: table-driven scoreboard bench for the serial subtractor
module tb_serial_sub_seq;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;
  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  vec_t vecs[$];
  serial_sub_seq_if #(.WIDTH(8)) s8 ();
  serial_sub_seq_if #(.WIDTH(1)) s1 ();
  serial_sub_seq #(.WIDTH(8)) dut  (.clk(clk), .rst(rst), .io(s8));
  serial_sub_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .io(s1));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] t;
    exp_t e;
    t = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.diff = t[7:0];
    e.bout = t[8];
    e.ovf  = (a[7] != b[7]) && (t[7] != a[7]);
    return e;
  endfunction
  task automatic accept_wait(input logic [7:0] a, input logic [7:0] b, input logic bin, input exp_t e, input string tag);
    int lat;
    exp_t got;
    chk({tag, "_in_ready"}, s8.in_ready, 1);
    s8.a = a;
    s8.b = b;
    s8.bin = bin;
    s8.in_valid = 1'b1;
    @(posedge clk);
    #1 s8.in_valid = 1'b0;
    sb_q.push_back(e);
    chk({tag, "_busy_run"}, {s8.busy, s8.in_ready}, 2'b10);
    lat = 0;
    while (!s8.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, lat, 8);
    got = sb_q.pop_front();
    chk({tag, "_diff"}, s8.diff, got.diff);
    chk({tag, "_bout"}, s8.bout, got.bout);
    chk({tag, "_ovf"}, s8.ovf, got.ovf);
  endtask
  task automatic release_out(input string tag);
    s8.out_ready = 1'b1;
    @(posedge clk);
    #1 s8.out_ready = 1'b0;
    chk({tag, "_idle"}, {s8.in_ready, s8.out_valid, s8.busy}, 3'b100);
  endtask
  initial begin
    int seen;
    vecs.push_back('{8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 1'b0});
    vecs.push_back('{8'd5,   8'd9,  1'b0, 8'hFC,  1'b1, 1'b0});
    vecs.push_back('{8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1});
    vecs.push_back('{8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1});
    vecs.push_back('{8'h00,  8'h00, 1'b1, 8'hFF,  1'b1, 1'b0});
    rst = 1'b1;
    {s8.in_valid, s8.a, s8.b, s8.bin, s8.out_ready} = '0;
    {s1.in_valid, s1.a, s1.b, s1.bin, s1.out_ready} = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_outputs", {s8.diff, s8.bout, s8.ovf, s8.out_valid, s8.busy, s8.in_ready}, 13'h1);
    foreach (vecs[i]) begin
      accept_wait(vecs[i].a, vecs[i].b, vecs[i].bin, '{vecs[i].diff, vecs[i].bout, vecs[i].ovf}, $sformatf("vec%0d", i));
      release_out($sformatf("vec%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic rbin;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      accept_wait(ra, rb, rbin, model(ra, rb, rbin), $sformatf("rnd%0d", i));
      release_out($sformatf("rnd%0d", i));
    end
    accept_wait(8'd200, 8'd55, 1'b0, '{8'd145, 1'b0, 1'b0}, "bp");
    s8.a = 8'd1;
    s8.b = 8'd1;
    s8.in_valid = 1'b1;
    s8.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk($sformatf("bp_hold%0d", i), {s8.out_valid, s8.in_ready, s8.busy, s8.diff}, {3'b101, 8'd145});
    end
    s8.in_valid = 1'b0;
    release_out("bp");
    chk("bp_diff_kept", {s8.diff, s8.bout, s8.ovf}, {8'd145, 2'b00});
    accept_wait(8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1}, "pre_rst");
    release_out("pre_rst");
    s8.a = 8'd100;
    s8.b = 8'd37;
    s8.in_valid = 1'b1;
    @(posedge clk);
    #1 s8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrun_rst", {s8.diff, s8.bout, s8.ovf, s8.out_valid, s8.busy, s8.in_ready}, 13'h1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (s8.out_valid) seen++;
    end
    chk("midrun_no_out", seen, 0);
    s1.a = 1'b0;
    s1.b = 1'b1;
    s1.bin = 1'b0;
    s1.in_valid = 1'b1;
    @(posedge clk);
    #1 s1.in_valid = 1'b0;
    seen = 0;
    while (!s1.out_valid && seen < 10) begin
      @(posedge clk);
      #1 seen++;
    end
    chk("w1_latency", seen, 1);
    chk("w1_result", {s1.diff, s1.bout, s1.ovf}, 3'b111);
    s1.out_ready = 1'b1;
    @(posedge clk);
    #1 s1.out_ready = 1'b0;
    chk("w1_idle", {s1.in_ready, s1.out_valid}, 2'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
